// File: rtl/knightrider_pkg.sv
// Shared widths, key indices, idle levels and source-state encoding for the
// knight rider input controller.
package knightrider_pkg;

  localparam int MODE_W  = 4;
  localparam int SPEED_W = 4;

  localparam int KEY_MODE_UP = 0;
  localparam int KEY_MODE_DN = 1;
  localparam int KEY_SPD_UP  = 2;
  localparam int KEY_SPD_DN  = 3;

  localparam logic SW_IDLE  = 1'b0;
  localparam logic SEL_IDLE = 1'b0;
  localparam logic KEY_IDLE = 1'b1;

  typedef enum logic {
    SRC_SW  = 1'b0,
    SRC_KEY = 1'b1
  } src_t;

endpackage

// File: rtl/knightrider_ctrl_debounce_bit.sv
// Single-bit 2-flop synchronizer followed by a stable-count debouncer.
module debounce_bit #(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   CNT_W           = 20,
  parameter logic IDLE            = 1'b0
) (
  input  logic clkin,
  input  logic rstn,
  input  logic din,
  output logic dout
);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // Level toggles on the edge where the counter already sits at the last count.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      cnt  <= '0;
      dout <= IDLE;
    end else if (sync2 == dout) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt  <= '0;
      dout <= sync2;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/knightrider_ctrl.sv
// Input front-end: debounced switches/keys drive mode and speed selections,
// with a one-cycle strobe whenever either value changes.
module knightrider_ctrl
  import knightrider_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic               clkin,
  input  logic               rstn,
  input  logic [7:0]         sw_raw,
  input  logic               sel_raw,
  input  logic [3:0]         key_raw,
  output logic [MODE_W-1:0]  mode,
  output logic [SPEED_W-1:0] speed,
  output logic               changed
);

  logic [7:0]         dsw;
  logic               dsel;
  logic [3:0]         dkey;
  logic [3:0]         dkey_q;
  logic [3:0]         press;
  src_t               src;
  src_t               src_nxt;
  logic [MODE_W-1:0]  mode_nxt;
  logic [SPEED_W-1:0] speed_nxt;
  logic               mode_up;
  logic               mode_dn;
  logic               spd_up;
  logic               spd_dn;

  debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .IDLE(SW_IDLE))
    u_sw [7:0] (.clkin(clkin), .rstn(rstn), .din(sw_raw), .dout(dsw));

  debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .IDLE(SEL_IDLE))
    u_sel (.clkin(clkin), .rstn(rstn), .din(sel_raw), .dout(dsel));

  debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .IDLE(KEY_IDLE))
    u_key [3:0] (.clkin(clkin), .rstn(rstn), .din(key_raw), .dout(dkey));

  // Keys are active-low: a press is a debounced 1-to-0 transition.
  assign press   = dkey_q & ~dkey;
  assign mode_up = press[KEY_MODE_UP];
  assign mode_dn = press[KEY_MODE_DN];
  assign spd_up  = press[KEY_SPD_UP];
  assign spd_dn  = press[KEY_SPD_DN];

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      dkey_q <= {4{KEY_IDLE}};
      src    <= SRC_SW;
    end else begin
      dkey_q <= dkey;
      src    <= src_nxt;
    end
  end

  always_comb begin
    src_nxt   = dsel ? SRC_KEY : SRC_SW;
    mode_nxt  = mode;
    speed_nxt = speed;
    case (src)
      SRC_SW: begin
        mode_nxt  = dsw[MODE_W-1:0];
        speed_nxt = dsw[7 -: SPEED_W];
      end
      SRC_KEY: begin
        if (mode_up && !mode_dn) mode_nxt = mode + MODE_W'(1);
        if (mode_dn && !mode_up) mode_nxt = mode - MODE_W'(1);
        if (spd_up && !spd_dn && speed != '1) speed_nxt = speed + SPEED_W'(1);
        if (spd_dn && !spd_up && speed != '0) speed_nxt = speed - SPEED_W'(1);
      end
      default: begin
        mode_nxt  = mode;
        speed_nxt = speed;
      end
    endcase
  end

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      mode    <= '0;
      speed   <= '0;
      changed <= 1'b0;
    end else begin
      mode    <= mode_nxt;
      speed   <= speed_nxt;
      changed <= (mode_nxt != mode) || (speed_nxt != speed);
    end
  end

endmodule

// File: tb/tb_knightrider_ctrl.sv
// Directed bench for knightrider_ctrl with a short debounce window.
module tb_knightrider_ctrl;

  logic       clkin = 1'b0;
  logic       rstn;
  logic [7:0] sw_raw;
  logic       sel_raw;
  logic [3:0] key_raw;
  logic [3:0] mode;
  logic [3:0] speed;
  logic       changed;

  int errors = 0;
  int checks = 0;
  int chg_total = 0;
  int base;

  knightrider_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clkin(clkin), .rstn(rstn), .sw_raw(sw_raw), .sel_raw(sel_raw),
    .key_raw(key_raw), .mode(mode), .speed(speed), .changed(changed)
  );

  always #5 clkin = ~clkin;

  always @(posedge clkin) if (changed) chg_total <= chg_total + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clkin);
      @(negedge clkin);
    end
  endtask

  task automatic press(input logic [3:0] mask, input int n);
    key_raw = ~mask;
    tick(n);
    key_raw = 4'hF;
    tick(12);
  endtask

  task automatic load_sw(input logic [7:0] v);
    sel_raw = 1'b0;
    sw_raw  = v;
    tick(15);
    sel_raw = 1'b1;
    tick(15);
  endtask

  initial begin
    rstn = 1'b0; sw_raw = 8'h00; sel_raw = 1'b0; key_raw = 4'hF;
    tick(3);
    chk("rst_mode", mode, 0);
    chk("rst_speed", speed, 0);
    chk("rst_changed", changed, 0);
    rstn = 1'b1;
    tick(3);

    // Exact 7-edge latency from a clean switch edge.
    sw_raw = 8'h5A;
    for (int e = 1; e <= 6; e++) begin
      tick(1);
      chk("pre_mode", mode, 0);
      chk("pre_changed", changed, 0);
    end
    tick(1);
    chk("lat_mode", mode, 4'hA);
    chk("lat_speed", speed, 4'h5);
    chk("lat_changed", changed, 1);
    tick(1);
    chk("lat_changed_off", changed, 0);
    chk("lat_pulses", chg_total, 1);

    // Bounce rejection on sw_raw[0].
    base = chg_total;
    for (int t = 0; t < 10; t++) begin
      sw_raw[0] = ~sw_raw[0];
      for (int c = 0; c < 3; c++) begin
        tick(1);
        if (mode !== 4'hA) chk("bounce_mode", mode, 4'hA);
      end
    end
    chk("bounce_mode_end", mode, 4'hA);
    chk("bounce_pulses", chg_total - base, 0);
    sw_raw[0] = 1'b1;
    tick(6);
    chk("settle_pre", mode, 4'hA);
    tick(1);
    chk("settle_mode", mode, 4'hB);

    // Key source: mode wraps both ways, hold gives a single step.
    load_sw(8'h0F);
    chk("key_start", mode, 4'hF);
    base = chg_total;
    press(4'b0001, 10);
    chk("mode_up_wrap", mode, 4'h0);
    chk("mode_up_pulse", chg_total - base, 1);
    press(4'b0010, 10);
    chk("mode_dn_wrap", mode, 4'hF);
    base = chg_total;
    press(4'b0001, 100);
    chk("hold_mode", mode, 4'h0);
    chk("hold_pulses", chg_total - base, 1);

    // Speed saturation at both ends.
    load_sw(8'hF3);
    base = chg_total;
    press(4'b0100, 10);
    chk("spd_sat_hi", speed, 4'hF);
    chk("spd_sat_hi_pulse", chg_total - base, 0);
    load_sw(8'h03);
    base = chg_total;
    press(4'b1000, 10);
    chk("spd_sat_lo", speed, 4'h0);
    chk("spd_sat_lo_pulse", chg_total - base, 0);

    // Opposing mode keys cancel; speed+ still applies.
    load_sw(8'h73);
    base = chg_total;
    press(4'b0111, 10);
    chk("simul_mode", mode, 4'h3);
    chk("simul_speed", speed, 4'h8);
    chk("simul_pulse", chg_total - base, 1);

    // Reset in the middle of a key debounce.
    sw_raw  = 8'h00;
    key_raw = 4'b1110;
    tick(3);
    #2 rstn = 1'b0;
    key_raw = 4'hF;
    #1;
    chk("mid_rst_mode", mode, 0);
    chk("mid_rst_speed", speed, 0);
    tick(2);
    rstn = 1'b1;
    base = chg_total;
    for (int c = 0; c < 30; c++) begin
      tick(1);
      if (mode !== 4'h0) chk("post_rst_mode", mode, 0);
    end
    chk("post_rst_mode_end", mode, 0);
    chk("post_rst_speed", speed, 0);
    chk("post_rst_pulses", chg_total - base, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/knightrider_ctrl.md
Name: knightrider_ctrl

Overview:
- Front-end input controller that produces the mode[3:0] and speed[3:0] selections consumed by the knight rider LED pattern generator.
- Synchronizes and debounces the raw board slide switches and push keys.
- Two selection sources:
  - Switch mode: values follow the slide switches directly.
  - Key mode: push keys step mode and speed up or down.
- Emits a one-cycle strobe whenever the selection changes.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to accept a new input level (10 ms at 50 MHz).
- CNT_W, 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clkin  input  1  board clock; all state is on its rising edge.
- rstn  input  1  asynchronous, active-low reset.
- sw_raw  input  8  raw slide switches; [3:0] = mode, [7:4] = speed.
- sel_raw  input  1  raw source-select switch; 0 = switches drive, 1 = keys drive.
- key_raw  input  4  raw push keys, active-low; [0] mode+, [1] mode-, [2] speed+, [3] speed-.
- mode  output  4  current mode selection.
- speed  output  4  current speed selection.
- changed  output  1  one-cycle pulse when mode or speed changes value.

Behaviour:
- Reset, asynchronous while rstn = 0:
  - mode = 0, speed = 0, changed = 0.
  - All synchronizer flops and debounced levels go to the idle level: sw = 0, sel = 0, key = 1.
  - All debounce counters go to 0.
- Synchronizer: every raw bit passes through a 2-flop synchronizer.
- Debounce, per bit:
  - Counter increments while the synced level differs from the debounced level.
  - Counter clears to 0 on any cycle where they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level toggles on that edge and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are fully rejected.
- Latency: a clean raw edge reaches the debounced level after 2 + DEBOUNCE_CYCLES clkin edges. The mode/speed registers update on the following edge. changed asserts in the same cycle mode/speed take their new value.
- Key press event: a 1-to-0 transition of a debounced key gives a one-cycle pulse. Release produces no event. Holding a key produces no auto-repeat.
- Switch source (debounced sel = 0): mode <= dsw[3:0] and speed <= dsw[7:4] every cycle. Key events are ignored.
- Key source (debounced sel = 1): registers hold their last value. Key events apply as follows:
  - mode+ : mode increments, wrapping 15 to 0.
  - mode- : mode decrements, wrapping 0 to 15.
  - speed+ : speed increments, saturating at 15.
  - speed- : speed decrements, saturating at 0.
  - mode+ and mode- in the same cycle: mode unchanged. The same rule applies to speed.
  - A mode event and a speed event in the same cycle: both apply.
- Source switch 1 to 0: the switch values load on the next edge; changed pulses only if the values differ.
- Source switch 0 to 1: the current values are retained; no change occurs.
- changed = registered (next_mode != mode) || (next_speed != speed). It is never asserted while values are unchanged.
- Reset mid-debounce: the counter is discarded; after release, the input is re-evaluated from the idle level.

State machine:
- Source FSM has two states, SRC_SW and SRC_KEY, selected by the debounced sel.
- Reset state is SRC_SW.

Decomposition:
- Shared package knightrider_pkg holds:
  - MODE_W = 4 and SPEED_W = 4.
  - Key index constants KEY_MODE_UP = 0, KEY_MODE_DN = 1, KEY_SPD_UP = 2, KEY_SPD_DN = 3.
  - Idle levels and the source-state encoding SRC_SW / SRC_KEY.
- One sub-module, debounce_bit: parameters DEBOUNCE_CYCLES and CNT_W, plus an IDLE reset level. It contains the 2-flop synchronizer, counter and debounced output.
  - Instantiated 13 times: 8 switches, 1 select, 4 keys.
  - The top level holds edge detection, the source FSM, mode/speed registers and changed.

Test Plan (DEBOUNCE_CYCLES = 4, CNT_W = 3):
- Reset release with all inputs idle, then sw_raw = 8'h5A held: mode = 4'hA and speed = 4'h5 appear exactly 7 edges after the sw change. changed pulses once; both outputs are 0 before that.
- Bounce rejection: toggle sw_raw[0] with 3-cycle pulses ten times, then settle high. No output change during bouncing; mode[0] = 1 exactly 7 edges after the final settle.
- Key source, mode = 15: press mode+ (low 10 cycles) giving mode = 0 with one changed pulse. Hold the key low 100 cycles: exactly one step occurs. Press mode- giving mode = 15.
- Key source, speed = 15: press speed+ with no change and no changed pulse. From speed = 0, press speed- with no change.
- Simultaneous press of mode+ and mode- plus speed+ in the same cycle, starting from mode = 3, speed = 7: mode stays 3, speed = 8, one changed pulse.
- Assert rstn low mid-debounce of a key press, release after 2 cycles: mode = 0, speed = 0, and no spurious event after reset.
